// File: rtl/mem_sched_pkg.sv
// Shared definitions for the time-sliced RAM scheduler: slot encodings and
// default RAM geometry.
package mem_sched_pkg;

  // One RAM access slot per clock, four clocks per CPU cycle
  typedef enum logic [1:0] {
    SLOT_CPU_RD = 2'd0,
    SLOT_CPU_WR = 2'd1,
    SLOT_VID    = 2'd2,
    SLOT_HOST   = 2'd3
  } slot_e;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mem_scheduler.sv
// Round-robin RAM scheduler: a fixed four-slot round shares one synchronous
// RAM between CPU read, CPU write, video fetch and a host port.
module mem_scheduler
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  output logic              cpu_ce,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  slot_e slot;
  slot_e slot_next;
  logic  vid_pending;
  logic  host_pending;

  // Slot counter state register; reset always restarts the round at the CPU read slot
  always_ff @(posedge clock) begin
    if (reset) begin
      slot <= SLOT_CPU_RD;
    end else begin
      slot <= slot_next;
    end
  end

  // Next slot plus the RAM port mux; every strobe is forced low while reset is held
  always_comb begin
    slot_next  = SLOT_CPU_RD;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    cpu_ce     = 1'b0;
    host_ready = 1'b0;
    case (slot)
      SLOT_CPU_RD: begin
        slot_next = SLOT_CPU_WR;
        mem_addr  = cpu_raddr;
      end
      SLOT_CPU_WR: begin
        slot_next = SLOT_VID;
        mem_addr  = cpu_waddr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      SLOT_VID: begin
        slot_next = SLOT_HOST;
        mem_addr  = vid_addr;
      end
      SLOT_HOST: begin
        slot_next = SLOT_CPU_RD;
        cpu_ce    = 1'b1;
        if (host_valid) begin
          mem_addr   = host_addr;
          mem_wdata  = host_wdata;
          mem_we     = host_we;
          host_ready = 1'b1;
        end
      end
      default: slot_next = SLOT_CPU_RD;
    endcase
    if (reset) begin
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      cpu_ce     = 1'b0;
      host_ready = 1'b0;
    end
  end

  // Capture RAM read data one slot after each address was presented and raise response pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rdata    <= '0;
      vid_data     <= '0;
      vid_ack      <= 1'b0;
      vid_pending  <= 1'b0;
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      host_pending <= 1'b0;
    end else begin
      vid_ack     <= 1'b0;
      host_rvalid <= 1'b0;
      case (slot)
        SLOT_CPU_RD: begin
          if (host_pending) begin
            host_rdata   <= mem_rdata;
            host_rvalid  <= 1'b1;
            host_pending <= 1'b0;
          end
        end
        SLOT_CPU_WR: begin
          cpu_rdata <= mem_rdata;
        end
        SLOT_VID: begin
          vid_pending <= vid_req;
        end
        SLOT_HOST: begin
          if (vid_pending) begin
            vid_data <= mem_rdata;
            vid_ack  <= 1'b1;
          end
          vid_pending <= 1'b0;
          if (host_valid && !host_we) begin
            host_pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_scheduler.md
MEM_SCHEDULER -- requirements
Module: mem_scheduler

Interface
REQ-001 Parameter ADDR_W, default 15, RAM address width in bits (32K bytes).
REQ-002 Parameter DATA_W, default 8, RAM data width in bits.
REQ-003 Port clock, input, 1: single clock, 4x the CPU rate; all logic is clocked on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port cpu_ce, output, 1: CPU clock enable; high in slot 3 only.
REQ-006 Port cpu_raddr, input, ADDR_W: CPU read address.
REQ-007 Port cpu_rdata, output, DATA_W: CPU read data.
REQ-008 Port cpu_waddr, input, ADDR_W: CPU write address.
REQ-009 Port cpu_wdata, input, DATA_W: CPU write data.
REQ-010 Port cpu_we, input, 1: CPU write request for the current CPU cycle.
REQ-011 Port vid_req, input, 1: video fetch request (level).
REQ-012 Port vid_addr, input, ADDR_W: video fetch address.
REQ-013 Port vid_ack, output, 1: one-cycle pulse; vid_data is valid.
REQ-014 Port vid_data, output, DATA_W: video fetch data.
REQ-015 Port host_valid, input, 1: host request valid.
REQ-016 Port host_we, input, 1: host request is a write.
REQ-017 Port host_addr, input, ADDR_W: host address.
REQ-018 Port host_wdata, input, DATA_W: host write data.
REQ-019 Port host_ready, output, 1: one-cycle pulse; host request accepted.
REQ-020 Port host_rvalid, output, 1: one-cycle pulse; host_rdata is valid.
REQ-021 Port host_rdata, output, DATA_W: host read data.
REQ-022 Port mem_addr, output, ADDR_W: RAM address.
REQ-023 Port mem_wdata, output, DATA_W: RAM write data.
REQ-024 Port mem_we, output, 1: RAM write strobe.
REQ-025 Port mem_rdata, input, DATA_W: RAM read data, registered, one-cycle latency.

Function
REQ-026 A 2-bit slot counter SHALL advance 0,1,2,3 and then wrap to 0, one slot per clock.
REQ-027 Slot 0 SHALL drive mem_addr=cpu_raddr with mem_we=0.
REQ-028 Slot 1 SHALL drive mem_addr=cpu_waddr, mem_wdata=cpu_wdata and mem_we=cpu_we.
REQ-029 Slot 1 SHALL register mem_rdata into cpu_rdata; cpu_rdata SHALL hold until the next slot 1.
REQ-030 Slot 2 SHALL drive mem_addr=vid_addr and mem_we=0; vid_req is sampled in this slot.
REQ-031 If vid_req was sampled high, slot 3 SHALL register mem_rdata into vid_data and pulse vid_ack.
REQ-032 If vid_req was sampled low, slot 3 SHALL keep vid_ack low and hold vid_data.
REQ-033 In slot 3 with host_valid=1, the block SHALL drive mem_addr=host_addr, mem_we=host_we and mem_wdata=host_wdata, and pulse host_ready.
REQ-034 In slot 3 with host_valid=0, the block SHALL drive mem_we=0 and keep host_ready low.
REQ-035 Host request fields SHALL be held stable by the requester from host_valid rising until host_ready.
REQ-036 An accepted host read SHALL set a pending flag; the following slot 0 SHALL register mem_rdata into host_rdata, pulse host_rvalid and clear the flag.
REQ-037 An accepted host write SHALL produce no host_rvalid.
REQ-038 Host latency: request accepted 0-3 clocks after host_valid rises; read data arrives 1 clock after host_ready.
REQ-039 A CPU write (slot 1) and a host write (slot 3) to the same address in one round SHALL leave the host value in RAM.
REQ-040 A host read of an address the CPU writes in the same round SHALL return the CPU value.
REQ-041 mem_we SHALL never be high in slot 0 or slot 2.
REQ-042 cpu_ce SHALL be exactly 1 in every 4 clocks and SHALL first assert in the 4th clock after reset release.

Reset
REQ-043 While reset is high: slot=0; cpu_ce, mem_we, vid_ack, host_ready and host_rvalid=0; cpu_rdata, vid_data, host_rdata and mem_addr=0; pending flag cleared.
REQ-044 If reset arrives mid-round, an accepted host read with no host_rvalid yet SHALL be dropped with no host_rvalid ever issued.
REQ-045 Slot 0 SHALL be the first slot after reset deasserts.

Structure
REQ-046 The shared package mem_sched_pkg SHALL hold the slot encodings (SLOT_CPU_RD=0, SLOT_CPU_WR=1, SLOT_VID=2, SLOT_HOST=3) and the ADDR_W and DATA_W defaults.
REQ-047 The block SHALL be a single module with no sub-modules; the slot counter and output muxes SHALL be inline.

Verification
REQ-048 Reset release, idle inputs -> cpu_ce high at clocks 4, 8, 12 and low elsewhere; mem_we stays 0.
REQ-049 RAM[0x1234]=0xA5, cpu_raddr=0x1234 -> cpu_rdata=0xA5 after slot 1 and held through slot 0 of the next round.
REQ-050 cpu_we=1, cpu_waddr=0x0100, cpu_wdata=0x3C; host write to 0x0100 with 0x7E in the same round -> RAM[0x0100]=0x7E.
REQ-051 RAM[0x4000]=0x55, vid_req=1, vid_addr=0x4000 -> vid_ack pulses in slot 3 with vid_data=0x55; vid_req=0 -> no vid_ack.
REQ-052 RAM[0x7FFF]=0x99, host read of 0x7FFF asserted in slot 0 -> host_ready in slot 3, host_rvalid with 0x99 in the next slot 0.
REQ-053 Reset pulsed in the clock after host_ready for a read -> no host_rvalid; slot restarts at 0.
